sid_voice_engine: RTL and testbench

Time-multiplexed, parametrised successor to the three-voice SID oscillator bank. One shared phase adder, LFSR stepper and waveform mixer serve NUM_VOICES voices. Per-voice state lives in register arrays and is swept once per clkEn tick. Outputs are a per-voice sample stream (valid/index/data) feeding the envelope and filter stages, and it adds a selectable mix mode and an overrun flag.

---
 rtl/sid_pkg.sv | 41 ++++
 rtl/sid_wave_mix.sv | 84 ++++++++
 rtl/sid_voice_engine.sv | 198 +++++++++++++++++++
 tb/tb_sid_voice_engine.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared constants, state type and noise tap helper for the SID voice engine
package sid_pkg;

    localparam int LFSR_W  = 23;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;

    localparam int PW_W    = 12;
    localparam int NOISE_W = 8;

    // Control register layout: ctrl[6:0] = iData[7:1]
    localparam int CTRL_W  = 7;
    localparam int C_SYNC  = 0;
    localparam int C_RING  = 1;
    localparam int C_TEST  = 2;
    localparam int C_TRI   = 3;
    localparam int C_SAW   = 4;
    localparam int C_PULSE = 5;
    localparam int C_NOISE = 6;

    // Register offsets within one voice's address window
    localparam int OFF_FREQ_LO = 0;
    localparam int OFF_FREQ_HI = 1;
    localparam int OFF_PW_LO   = 2;
    localparam int OFF_PW_HI   = 3;
    localparam int OFF_CTRL    = 4;

    localparam int MIX_OR  = 0;
    localparam int MIX_AND = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Noise output taps, MSB first: lfsr bits 20,18,14,11,9,5,2,0
    function automatic logic [NOISE_W-1:0] noise_bits(input logic [LFSR_W-1:0] l);
        return {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0]};
    endfunction

endpackage

// File: rtl/sid_wave_mix.sv
// rtl/sid_wave_mix.sv - combinational waveform generator and mixer for one voice slot
// Ports:
//   p_top    : phase bits [ACC_W-1 -: OUT_W+1] of the voice being processed
//   pw       : 12-bit pulse width
//   noise_in : 8 noise bits picked from the voice LFSR
//   en_*     : waveform enables from the control register
//   ring     : ring-mod enable; ring_msb is the source voice's snapshot MSB
//   sample   : mixed OUT_W-bit unsigned sample
import sid_pkg::*;

module sid_wave_mix #(
    parameter int OUT_W    = 12,
    parameter int MIX_MODE = MIX_OR
) (
    input  logic [OUT_W:0]       p_top,
    input  logic [PW_W-1:0]      pw,
    input  logic [NOISE_W-1:0]   noise_in,
    input  logic                 en_noise,
    input  logic                 en_pulse,
    input  logic                 en_saw,
    input  logic                 en_tri,
    input  logic                 ring,
    input  logic                 ring_msb,
    output logic [OUT_W-1:0]     sample
);

    logic [OUT_W-1:0] saw;
    logic [OUT_W-1:0] tri_raw;
    logic [OUT_W-1:0] tri_w;
    logic [OUT_W-1:0] pulse;
    logic [OUT_W-1:0] pw_s;
    logic [OUT_W-1:0] noise;
    logic [OUT_W-1:0] or_acc;
    logic [OUT_W-1:0] and_acc;

    // Pulse width and noise are fixed-width fields; align them to the top of the sample.
    if (OUT_W >= PW_W) begin : g_pw_wide
        assign pw_s = OUT_W'(pw) << (OUT_W - PW_W);
    end else begin : g_pw_narrow
        assign pw_s = pw[PW_W-1 -: OUT_W];
    end

    if (OUT_W >= NOISE_W) begin : g_noise_wide
        assign noise = OUT_W'(noise_in) << (OUT_W - NOISE_W);
    end else begin : g_noise_narrow
        assign noise = noise_in[NOISE_W-1 -: OUT_W];
    end

    always_comb begin
        saw     = p_top[OUT_W:1];
        tri_raw = p_top[OUT_W-1:0];
        // Triangle folds on the MSB; ring modulation replaces that fold with MSB xor source MSB.
        tri_w   = (p_top[OUT_W] ^ (ring & ring_msb)) ? ~tri_raw : tri_raw;
        pulse   = (saw <= pw_s) ? '0 : '1;

        or_acc  = '0;
        and_acc = '1;
        if (en_tri) begin
            or_acc  = or_acc | tri_w;
            and_acc = and_acc & tri_w;
        end
        if (en_saw) begin
            or_acc  = or_acc | saw;
            and_acc = and_acc & saw;
        end
        if (en_pulse) begin
            or_acc  = or_acc | pulse;
            and_acc = and_acc & pulse;
        end
        if (en_noise) begin
            or_acc  = or_acc | noise;
            and_acc = and_acc & noise;
        end

        if (!(en_tri | en_saw | en_pulse | en_noise)) begin
            sample = '0;
        end else if (MIX_MODE == MIX_AND) begin
            sample = and_acc;
        end else begin
            sample = or_acc;
        end
    end

endmodule

// File: rtl/sid_voice_engine.sv
// rtl/sid_voice_engine.sv - time-multiplexed SID oscillator bank, one voice per cycle per clkEn tick
// Ports:
//   clk, iRst        : clock, synchronous active-high reset
//   clkEn            : oscillator tick; starts one sweep over all voices
//   iWE/iAddr/iData  : register write port, voice v at base v*REG_STRIDE
//   oValid/oVoice/oOut : one registered sample per voice per sweep
//   oBusy            : sweep in progress
//   oOverrun         : sticky, a tick arrived while a sweep was still running
import sid_pkg::*;

module sid_voice_engine #(
    parameter int NUM_VOICES = 3,
    parameter int ACC_W      = 24,
    parameter int FREQ_W     = 16,
    parameter int OUT_W      = 12,
    parameter int NOISE_TAP  = 19,
    parameter int REG_STRIDE = 7,
    parameter int MIX_MODE   = 0
) (
    input  logic             clk,
    input  logic             iRst,
    input  logic             clkEn,
    input  logic             iWE,
    input  logic [4:0]       iAddr,
    input  logic [7:0]       iData,
    output logic             oValid,
    output logic [2:0]       oVoice,
    output logic [OUT_W-1:0] oOut,
    output logic             oBusy,
    output logic             oOverrun
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [ACC_W-1:0]  phase_q [NUM_VOICES];
    logic [ACC_W-1:0]  phase_d [NUM_VOICES];
    logic [15:0]       freq_q  [NUM_VOICES];
    logic [15:0]       freq_d  [NUM_VOICES];
    logic [PW_W-1:0]   pw_q    [NUM_VOICES];
    logic [PW_W-1:0]   pw_d    [NUM_VOICES];
    logic [CTRL_W-1:0] ctrl_q  [NUM_VOICES];
    logic [CTRL_W-1:0] ctrl_d  [NUM_VOICES];
    logic [LFSR_W-1:0] lfsr_q  [NUM_VOICES];
    logic [LFSR_W-1:0] lfsr_d  [NUM_VOICES];

    logic [NUM_VOICES-1:0] msb_now_q,   msb_now_d;
    logic [NUM_VOICES-1:0] msb_lag_q,   msb_lag_d;
    logic [NUM_VOICES-1:0] noise_lag_q, noise_lag_d;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q,     cnt_d;
    logic             valid_q,   valid_d;
    logic [2:0]       voice_q,   voice_d;
    logic [OUT_W-1:0] out_q,     out_d;
    logic             overrun_q, overrun_d;

    logic [VW-1:0]     cur;
    logic [VW-1:0]     src;
    logic [ACC_W-1:0]  cur_phase;
    logic [CTRL_W-1:0] cur_ctrl;
    logic [ACC_W-1:0]  addend;
    logic              sync_hit;
    logic              last;
    logic [OUT_W-1:0]  wave_sample;

    assign cur       = cnt_q[VW-1:0];
    assign src       = (cur == '0) ? VW'(NUM_VOICES - 1) : cur - 1'b1;
    assign cur_phase = phase_q[cur];
    assign cur_ctrl  = ctrl_q[cur];
    assign addend    = ACC_W'(freq_q[cur][FREQ_W-1:0]);
    // Source MSB fell between the previous snapshot and this one.
    assign sync_hit  = cur_ctrl[C_SYNC] & ~msb_now_q[src] & msb_lag_q[src];
    assign last      = (cnt_q == 3'(NUM_VOICES - 1));

    sid_wave_mix #(
        .OUT_W    (OUT_W),
        .MIX_MODE (MIX_MODE)
    ) u_wave_mix (
        .p_top    (cur_phase[ACC_W-1 -: OUT_W+1]),
        .pw       (pw_q[cur]),
        .noise_in (noise_bits(lfsr_q[cur])),
        .en_noise (cur_ctrl[C_NOISE]),
        .en_pulse (cur_ctrl[C_PULSE]),
        .en_saw   (cur_ctrl[C_SAW]),
        .en_tri   (cur_ctrl[C_TRI]),
        .ring     (cur_ctrl[C_RING]),
        .ring_msb (msb_now_q[src]),
        .sample   (wave_sample)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        voice_d     = voice_q;
        out_d       = out_q;
        overrun_d   = overrun_q;
        phase_d     = phase_q;
        freq_d      = freq_q;
        pw_d        = pw_q;
        ctrl_d      = ctrl_q;
        lfsr_d      = lfsr_q;
        msb_now_d   = msb_now_q;
        msb_lag_d   = msb_lag_q;
        noise_lag_d = noise_lag_q;

        // Register writes; the sweep reads the _q copies so it sees pre-write values.
        if (iWE) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (int'(iAddr) == v * REG_STRIDE + OFF_FREQ_LO) freq_d[v][7:0]  = iData;
                if (int'(iAddr) == v * REG_STRIDE + OFF_FREQ_HI) freq_d[v][15:8] = iData;
                if (int'(iAddr) == v * REG_STRIDE + OFF_PW_LO)   pw_d[v][7:0]    = iData;
                if (int'(iAddr) == v * REG_STRIDE + OFF_PW_HI)   pw_d[v][11:8]   = iData[3:0];
                if (int'(iAddr) == v * REG_STRIDE + OFF_CTRL)    ctrl_d[v]       = iData[7:1];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (clkEn) state_d = ST_SNAP;
            end
            ST_SNAP: begin
                // The lag shifts here rather than per voice so every voice in the sweep,
                // including ones whose source was already processed, compares against
                // the previous sweep's MSB.
                msb_lag_d = msb_now_q;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    msb_now_d[v] = phase_q[v][ACC_W-1];
                end
                cnt_d   = '0;
                state_d = ST_RUN;
                if (clkEn) overrun_d = 1'b1;
            end
            ST_RUN: begin
                phase_d[cur]     = (cur_ctrl[C_TEST] | sync_hit) ? '0 : cur_phase + addend;
                noise_lag_d[cur] = cur_phase[NOISE_TAP];
                if (cur_phase[NOISE_TAP] & ~noise_lag_q[cur]) begin
                    lfsr_d[cur] = {lfsr_q[cur][LFSR_W-2:0],
                                   (lfsr_q[cur][22] ^ lfsr_q[cur][21]) | cur_ctrl[C_TEST]};
                end
                valid_d = 1'b1;
                voice_d = cnt_q;
                out_d   = wave_sample;
                if (last) begin
                    // A tick landing on the final voice starts the next sweep directly.
                    state_d = clkEn ? ST_SNAP : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (clkEn) overrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            voice_q     <= '0;
            out_q       <= '0;
            overrun_q   <= 1'b0;
            msb_now_q   <= '0;
            msb_lag_q   <= '0;
            noise_lag_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                freq_q[v]  <= '0;
                pw_q[v]    <= '0;
                ctrl_q[v]  <= '0;
                lfsr_q[v]  <= LFSR_SEED;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            voice_q     <= voice_d;
            out_q       <= out_d;
            overrun_q   <= overrun_d;
            msb_now_q   <= msb_now_d;
            msb_lag_q   <= msb_lag_d;
            noise_lag_q <= noise_lag_d;
            phase_q     <= phase_d;
            freq_q      <= freq_d;
            pw_q        <= pw_d;
            ctrl_q      <= ctrl_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign oValid   = valid_q;
    assign oVoice   = voice_q;
    assign oOut     = out_q;
    assign oBusy    = (state_q != ST_IDLE);
    assign oOverrun = overrun_q;

endmodule

// File: tb/tb_sid_voice_engine.sv
// tb/tb_sid_voice_engine.sv - directed self-checking bench for sid_voice_engine
module tb_sid_voice_engine;

    logic        clk = 1'b0;
    logic        iRst;
    logic        clkEn;
    logic        iWE;
    logic [4:0]  iAddr;
    logic [7:0]  iData;
    logic        oValid;
    logic [2:0]  oVoice;
    logic [11:0] oOut;
    logic        oBusy;
    logic        oOverrun;

    int checks = 0;
    int errors = 0;

    logic [11:0] samp [3];
    int          pos  [3];
    int          nvalid;

    sid_voice_engine dut (
        .clk      (clk),
        .iRst     (iRst),
        .clkEn    (clkEn),
        .iWE      (iWE),
        .iAddr    (iAddr),
        .iData    (iData),
        .oValid   (oValid),
        .oVoice   (oVoice),
        .oOut     (oOut),
        .oBusy    (oBusy),
        .oOverrun (oOverrun)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        iRst = 1'b1;
        clkEn = 1'b0;
        iWE = 1'b0;
        @(negedge clk);
        @(negedge clk);
        iRst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        iWE = 1'b1;
        iAddr = a;
        iData = d;
        @(negedge clk);
        iWE = 1'b0;
    endtask

    // One clkEn pulse, then five sampling negedges (k = 2..6 after the accepting edge).
    task automatic tick();
        for (int v = 0; v < 3; v++) begin
            samp[v] = 12'hxxx;
            pos[v] = 0;
        end
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (oValid) begin
                samp[oVoice] = oOut;
                pos[oVoice] = k;
                nvalid++;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({oValid, oVoice, oOut, oBusy, oOverrun} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b voice=%0d out=%h busy=%b ovr=%b required all 0",
                     oValid, oVoice, oOut, oBusy, oOverrun);
        end
    endtask

    task automatic test_saw();
        do_reset();
        wr(5'd0, 8'h00);
        wr(5'd1, 8'h10);
        wr(5'd4, 8'h20);
        wr(5'd5, 8'hFF);
        wr(5'd6, 8'hFF);
        wr(5'd21, 8'hFF);
        wr(5'd25, 8'h20);
        ticks(256);
        nvalid = 0;
        tick();
        checks++;
        if (samp[0] !== 12'h100) begin
            errors++;
            $display("FAIL saw_tick257: got %h required 100", samp[0]);
        end
        checks++;
        if (samp[1] !== 12'h000 || samp[2] !== 12'h000) begin
            errors++;
            $display("FAIL idle_voices: got %h %h required 000 000", samp[1], samp[2]);
        end
        checks++;
        if (pos[0] != 3 || pos[1] != 4 || pos[2] != 5) begin
            errors++;
            $display("FAIL valid_latency: got %0d %0d %0d required 3 4 5", pos[0], pos[1], pos[2]);
        end
        checks++;
        if (nvalid != 3 || oOverrun !== 1'b0) begin
            errors++;
            $display("FAIL single_sweep: got valids=%0d ovr=%b required 3 0", nvalid, oOverrun);
        end
    endtask

    task automatic test_pulse();
        int bad;
        do_reset();
        wr(5'd7, 8'h00);
        wr(5'd8, 8'h40);
        wr(5'd9, 8'h00);
        wr(5'd10, 8'hF8);
        wr(5'd11, 8'h40);
        bad = 0;
        for (int t = 1; t <= 513; t++) begin
            tick();
            if (samp[1] !== 12'h000 && bad == 0) bad = t;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pulse_low: first nonzero at tick %0d required none through 513", bad);
        end
        tick();
        checks++;
        if (samp[1] !== 12'hFFF) begin
            errors++;
            $display("FAIL pulse_high_tick514: got %h required fff", samp[1]);
        end
    endtask

    task automatic test_sync();
        do_reset();
        wr(5'd0, 8'h00);
        wr(5'd1, 8'h80);
        wr(5'd7, 8'h00);
        wr(5'd8, 8'h80);
        wr(5'd14, 8'h00);
        wr(5'd15, 8'h01);
        wr(5'd18, 8'h22);
        ticks(511);
        tick();
        checks++;
        if (samp[2] !== 12'h01F) begin
            errors++;
            $display("FAIL sync_tick512: got %h required 01f", samp[2]);
        end
        tick();
        checks++;
        if (samp[2] !== 12'h020) begin
            errors++;
            $display("FAIL sync_tick513: got %h required 020", samp[2]);
        end
        tick();
        checks++;
        if (samp[2] !== 12'h000) begin
            errors++;
            $display("FAIL sync_tick514: got %h required 000", samp[2]);
        end
    endtask

    task automatic test_mix_or();
        do_reset();
        wr(5'd0, 8'h00);
        wr(5'd1, 8'h80);
        wr(5'd4, 8'h30);
        ticks(32);
        tick();
        checks++;
        if (samp[0] !== 12'h300) begin
            errors++;
            $display("FAIL mix_or_tick33: got %h required 300", samp[0]);
        end
        ticks(266);
        tick();
        checks++;
        if (samp[0] !== 12'hD5F) begin
            errors++;
            $display("FAIL mix_or_tick300: got %h required d5f", samp[0]);
        end
    endtask

    task automatic test_test_bit();
        int bad;
        do_reset();
        wr(5'd0, 8'h00);
        wr(5'd1, 8'h10);
        wr(5'd4, 8'h20);
        ticks(3);
        wr(5'd4, 8'h28);
        tick();
        checks++;
        if (samp[0] !== 12'h003) begin
            errors++;
            $display("FAIL test_first: got %h required 003", samp[0]);
        end
        bad = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (samp[0] !== 12'h000 && bad == 0) bad = t;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL test_hold: first nonzero at held tick %0d required none", bad);
        end
        wr(5'd4, 8'h20);
        tick();
        checks++;
        if (samp[0] !== 12'h000) begin
            errors++;
            $display("FAIL test_release0: got %h required 000", samp[0]);
        end
        tick();
        checks++;
        if (samp[0] !== 12'h001) begin
            errors++;
            $display("FAIL test_release1: got %h required 001", samp[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] v0 [2];
        int n0;
        do_reset();
        wr(5'd0, 8'h00);
        wr(5'd1, 8'h10);
        wr(5'd4, 8'h20);
        nvalid = 0;
        n0 = 0;
        clkEn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (oValid) begin
                nvalid++;
                if (oVoice == 3'd0 && n0 < 2) begin
                    v0[n0] = oOut;
                    n0++;
                end
            end
            if (k == 1 || k == 5) clkEn = 1'b0;
            if (k == 4) clkEn = 1'b1;
        end
        checks++;
        if (nvalid != 6 || oOverrun !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: got valids=%0d ovr=%b required 6 0", nvalid, oOverrun);
        end
        checks++;
        if (n0 != 2 || v0[0] !== 12'h000 || v0[1] !== 12'h001) begin
            errors++;
            $display("FAIL back_to_back_v0: got n=%0d %h %h required 2 000 001", n0, v0[0], v0[1]);
        end
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle: got busy=%b required 0", oBusy);
        end
    endtask

    task automatic test_overrun();
        int t0 [3];
        int n0;
        logic ov1;
        do_reset();
        nvalid = 0;
        n0 = 0;
        ov1 = 1'bx;
        clkEn = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) ov1 = oOverrun;
            if (oValid) begin
                nvalid++;
                if (oVoice == 3'd0 && n0 < 3) begin
                    t0[n0] = k;
                    n0++;
                end
            end
            if (k == 12) clkEn = 1'b0;
        end
        checks++;
        if (ov1 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early: got %b required 0", ov1);
        end
        checks++;
        if (oOverrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b required 1", oOverrun);
        end
        checks++;
        if (nvalid != 9) begin
            errors++;
            $display("FAIL overrun_valids: got %0d required 9", nvalid);
        end
        checks++;
        if (n0 != 3 || t0[1] - t0[0] != 4 || t0[2] - t0[1] != 4) begin
            errors++;
            $display("FAIL overrun_period: got n=%0d gaps %0d %0d required 3 4 4",
                     n0, t0[1] - t0[0], t0[2] - t0[1]);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        do_reset();
        wr(5'd0, 8'h00);
        wr(5'd1, 8'h10);
        wr(5'd4, 8'h20);
        ticks(3);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (oValid !== 1'b1 || oVoice !== 3'd0 || oOut !== 12'h003) begin
            errors++;
            $display("FAIL mid_v0: got valid=%b voice=%0d out=%h required 1 0 003", oValid, oVoice, oOut);
        end
        iRst = 1'b1;
        @(negedge clk);
        checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b busy=%b required 0 0", oValid, oBusy);
        end
        iRst = 1'b0;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (oValid === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL mid_no_stray: got %0d valids required 0", stray);
        end
        wr(5'd1, 8'h10);
        wr(5'd4, 8'h20);
        tick();
        checks++;
        if (samp[0] !== 12'h000) begin
            errors++;
            $display("FAIL mid_phase0: got %h required 000", samp[0]);
        end
        tick();
        checks++;
        if (samp[0] !== 12'h001) begin
            errors++;
            $display("FAIL mid_phase1: got %h required 001", samp[0]);
        end
    endtask

    initial begin
        iRst = 1'b1;
        clkEn = 1'b0;
        iWE = 1'b0;
        iAddr = '0;
        iData = '0;
        nvalid = 0;
        @(negedge clk);
        test_reset();
        test_saw();
        test_pulse();
        test_sync();
        test_mix_or();
        test_test_bit();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
